// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment glyph table and bus constants
// Glyphs are active-low, bits 6:0 = g..a, indexed by the nibble they show.
package seg_pkg;

  localparam int SEG_DP = 7;
  localparam logic [6:0] SEG_BLANK = 7'h7f;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - seven-segment pattern back to hex nibble
// Patterns not in the glyph table (blank included) decode to 0 with bad set.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       bad
);

  always_comb begin
    nibble = '0;
    bad    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH[i]) begin
        nibble = 4'(i);
        bad    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - capture a multiplexed 7-segment scan into a frame word
// Debounces each digit dwell, decodes it, and presents complete scans on valid/ready.
module seg_capture
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   out_value,
  output logic [DIGITS-1:0]     out_dp,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [DIGITS+7:0]    prev;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 latched, latched_nxt;
  logic [DIGITS-1:0]    seen, seen_nxt;
  logic [4*DIGITS-1:0]  dig_val, frame_val;
  logic [DIGITS-1:0]    dig_dp, dig_bad, frame_dp, frame_bad;
  logic [IW-1:0]        idx;
  int                   nzero;
  logic                 qual, same, accept, complete;
  logic [3:0]           nib;
  logic                 bad;

  seg_pattern_decode u_decode (
    .pattern (seg[6:0]),
    .nibble  (nib),
    .bad     (bad)
  );

  always_comb begin
    nzero = 0;
    idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        nzero = nzero + 1;
        idx   = IW'(i);
      end
    end
    qual = (nzero == 1);
    same = ({an, seg} == prev);
    cnt_nxt = '0;
    if (qual && same)
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    // A dwell is accepted once; latched holds off re-acceptance until {an,seg} changes.
    accept      = qual && !(latched && same) && (cnt_nxt == CNT_HIT);
    latched_nxt = qual && ((same && latched) || accept);
    seen_nxt    = seen;
    if (accept)
      seen_nxt[idx] = 1'b1;
    complete  = accept && (&seen_nxt);
    frame_val = dig_val;
    frame_dp  = dig_dp;
    frame_bad = dig_bad;
    if (accept) begin
      frame_val[4*int'(idx) +: 4] = nib;
      frame_dp[idx]               = ~seg[SEG_DP];
      frame_bad[idx]              = bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '1;
      cnt       <= '0;
      latched   <= 1'b0;
      seen      <= '0;
      dig_val   <= '0;
      dig_dp    <= '0;
      dig_bad   <= '0;
      out_value <= '0;
      out_dp    <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      prev    <= {an, seg};
      cnt     <= cnt_nxt;
      latched <= latched_nxt;
      dig_val <= frame_val;
      dig_dp  <= frame_dp;
      dig_bad <= frame_bad;
      seen    <= complete ? '0 : seen_nxt;
      if (out_valid && out_ready) begin
        overrun   <= 1'b0;
        out_valid <= complete;
        if (complete) begin
          out_value <= frame_val;
          out_dp    <= frame_dp;
          out_err   <= |frame_bad;
        end
      end else if (complete) begin
        // Held frame wins; the new one is dropped and flagged.
        if (out_valid) begin
          overrun <= 1'b1;
        end else begin
          out_value <= frame_val;
          out_dp    <= frame_dp;
          out_err   <= |frame_bad;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed bench for seg_capture
// Scan vectors from a table, then hand sequences for dwell, overrun and reset cases.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] out_value;
  logic [3:0]  out_dp;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  seg_capture #(.DIGITS(4), .STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .an        (an),
    .out_value (out_value),
    .out_dp    (out_dp),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] segs;
    logic [15:0] exp_val;
    logic [3:0]  exp_dp;
    logic        exp_err;
  } scan_t;

  scan_t       vec [6];
  int          checks = 0;
  int          errors = 0;
  int          pulses;
  logic [15:0] cap_val;
  logic [3:0]  cap_dp;
  logic        cap_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid && out_ready) begin
      pulses++;
      cap_val = out_value;
      cap_dp  = out_dp;
      cap_err = out_err;
    end
  endtask

  task automatic dwell(input int k, input logic [7:0] s, input int n);
    an  = ~(4'(1) << k);
    seg = s;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    an  = 4'hf;
    seg = 8'hff;
    repeat (n) tick();
  endtask

  task automatic scan(input logic [31:0] segs);
    for (int k = 0; k < 4; k++)
      dwell(k, segs[8*k +: 8], 8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vec[0] = '{32'ha4b09979, 16'h2341, 4'b0001, 1'b0};
    vec[1] = '{32'ha4ff9979, 16'h2041, 4'b0001, 1'b1};
    vec[2] = '{32'hc0c0c0c0, 16'h0000, 4'b0000, 1'b0};
    vec[3] = '{32'h8ea10880, 16'hfda8, 4'b0010, 1'b0};
    vec[4] = '{32'h03468690, 16'hbce9, 4'b1100, 1'b0};
    vec[5] = '{32'h8292f8d5, 16'h6570, 4'b0000, 1'b1};

    rst = 1'b1; out_ready = 1'b1; an = 4'hf; seg = 8'hff;
    pulses = 0; cap_val = '0; cap_dp = '0; cap_err = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_valid", out_valid, 0);
    chk("reset_value", out_value, 0);
    chk("reset_overrun", overrun, 0);
    idle(2);

    for (int v = 0; v < 6; v++) begin
      pulses = 0;
      scan(vec[v].segs);
      chk($sformatf("scan%0d_pulses", v), pulses, 1);
      chk($sformatf("scan%0d_value", v), cap_val, vec[v].exp_val);
      chk($sformatf("scan%0d_dp", v), cap_dp, vec[v].exp_dp);
      chk($sformatf("scan%0d_err", v), cap_err, vec[v].exp_err);
    end

    // Digit 0 never holds one pattern long enough.
    do_reset();
    pulses = 0;
    dwell(0, 8'hc0, 3);
    dwell(0, 8'hf9, 2);
    dwell(1, 8'h99, 8);
    dwell(2, 8'hb0, 8);
    dwell(3, 8'ha4, 8);
    chk("short_dwell_pulses", pulses, 0);
    chk("short_dwell_valid", out_valid, 0);

    // Unqualified anode cycles restart the stability count.
    do_reset();
    pulses = 0;
    dwell(0, 8'h79, 3);
    an = 4'hf; tick();
    dwell(0, 8'h79, 3);
    an = 4'b0011; tick();
    dwell(0, 8'h79, 3);
    dwell(1, 8'h99, 8);
    dwell(2, 8'hb0, 8);
    dwell(3, 8'ha4, 8);
    chk("glitch_pulses", pulses, 0);
    dwell(0, 8'h79, 3);
    chk("glitch_3cyc_valid", out_valid, 0);
    dwell(0, 8'h79, 1);
    chk("glitch_4cyc_valid", out_valid, 1);
    chk("glitch_value", out_value, 16'h2341);
    idle(2);

    // Overrun while the consumer stalls.
    do_reset();
    out_ready = 1'b0;
    scan(vec[0].segs);
    chk("stall1_valid", out_valid, 1);
    chk("stall1_overrun", overrun, 0);
    scan(vec[2].segs);
    chk("stall2_value", out_value, 16'h2341);
    chk("stall2_dp", out_dp, 4'b0001);
    chk("stall2_valid", out_valid, 1);
    chk("stall2_overrun", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("xfer_valid", out_valid, 0);
    chk("xfer_overrun", overrun, 0);

    // Reset mid-scan discards the held frame and the partial one.
    scan(vec[0].segs);
    dwell(0, 8'hc0, 8);
    dwell(1, 8'hc0, 8);
    dwell(2, 8'hc0, 8);
    chk("pre_rst_valid", out_valid, 1);
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_value", out_value, 0);
    chk("rst_dp", out_dp, 0);
    chk("rst_overrun", overrun, 0);
    out_ready = 1'b1;
    pulses = 0;
    dwell(3, 8'ha4, 8);
    chk("post_rst_partial", pulses, 0);
    scan(vec[0].segs);
    chk("post_rst_pulses", pulses, 1);
    chk("post_rst_value", cap_val, 16'h2341);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
